// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sevenseg_pkg;

  typedef enum logic [0:0] {
    BLANK,
    SHOW
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK    = 7'b1111111;
  localparam logic [3:0] NIBBLE_BLANK = 4'hF;

endpackage

// File: rtl/sevenseg_hex.sv
// Nibble to active-low {a,b,c,d,e,f,g} decoder; codes 10-15 render blank.
module sevenseg_hex
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  always_comb begin
    segs = SEG_BLANK;
    case (nibble)
      4'd0: segs = 7'b0000001;
      4'd1: segs = 7'b1001111;
      4'd2: segs = 7'b0010010;
      4'd3: segs = 7'b0000110;
      4'd4: segs = 7'b1001100;
      4'd5: segs = 7'b0100100;
      4'd6: segs = 7'b0100000;
      4'd7: segs = 7'b0001111;
      4'd8: segs = 7'b0000000;
      4'd9: segs = 7'b0001100;
      default: segs = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Define SEVENSEG_LZB_EN to enable leading-zero blanking.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 2000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic                      load,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                segs,
  output logic                      frame_done
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntLast  = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankLim = CntW'(BLANK_CYCLES);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || REFRESH_DIV < 2 ||
      BLANK_CYCLES >= REFRESH_DIV) begin : g_param_check
    $error("sevenseg_scan_ctrl: illegal NUM_DIGITS/REFRESH_DIV/BLANK_CYCLES");
  end

  logic [CntW-1:0]         slot_cnt_q, slot_cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  scan_state_t             state_q, state_d;
  logic [4*NUM_DIGITS-1:0] active_q, shadow_q;
  logic                    pending_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              segs_q, segs_d;
  logic                    slot_end, frame_end;
  logic [3:0]              cur_nibble, dec_nibble;
  logic [6:0]              dec_segs;
  logic                    lz_suppress;

  always_comb begin
    slot_end   = (slot_cnt_q == CntLast);
    frame_end  = slot_end && (idx_q == IdxLast);
    slot_cnt_d = slot_end ? '0 : slot_cnt_q + CntW'(1);
    idx_d      = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end
    // State follows the slot position the counter is about to take.
    state_d = (slot_cnt_d < BlankLim) ? BLANK : SHOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q <= '0;
      idx_q      <= '0;
      state_q    <= BLANK;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      state_q    <= state_d;
    end
  end

  // A load coinciding with the commit bypasses the shadow so it is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= '1;
      shadow_q  <= '1;
      pending_q <= 1'b0;
    end else if (load && frame_end) begin
      active_q  <= data_in;
      shadow_q  <= data_in;
      pending_q <= 1'b0;
    end else if (frame_end && pending_q) begin
      active_q  <= shadow_q;
      pending_q <= 1'b0;
    end else if (load) begin
      shadow_q  <= data_in;
      pending_q <= 1'b1;
    end
  end

  assign cur_nibble = active_q[{idx_q, 2'b00} +: 4];

`ifdef SEVENSEG_LZB_EN
  always_comb begin
    lz_suppress = 1'b0;
    if (idx_q != '0) begin
      lz_suppress = 1'b1;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
        if (k >= int'(idx_q) && active_q[4*k +: 4] != 4'h0) lz_suppress = 1'b0;
      end
    end
  end
`else
  assign lz_suppress = 1'b0;
`endif

  assign dec_nibble = lz_suppress ? NIBBLE_BLANK : cur_nibble;

  sevenseg_hex u_hex (
    .nibble (dec_nibble),
    .segs   (dec_segs)
  );

  always_comb begin
    an_d   = '1;
    segs_d = SEG_BLANK;
    if (state_q == SHOW && digit_en[idx_q]) begin
      an_d[idx_q] = 1'b0;
      segs_d      = dec_segs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q   <= '1;
      segs_q <= SEG_BLANK;
    end else begin
      an_q   <= an_d;
      segs_q <= segs_d;
    end
  end

  assign an         = an_q;
  assign segs       = segs_q;
  assign frame_done = frame_end;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Randomized self-checking bench for sevenseg_scan_ctrl against a cycle-indexed display model.
module tb_sevenseg_scan_ctrl;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = N * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = '0;
  logic        load = 1'b0;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  an;
  logic [6:0]  segs;
  logic        frame_done;

  always #5 clk = ~clk;

  sevenseg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .load       (load),
    .digit_en   (digit_en),
    .an         (an),
    .segs       (segs),
    .frame_done (frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: k is the cycle index since reset release; the active word as seen during
  // the previous cycle determines what the registered outputs show now.
  int         k;
  logic [3:0] m_active [N];
  logic [3:0] m_shadow [N];
  logic       m_pending;
  logic [3:0] p_active [N];
  logic [3:0] p_en;
  logic [3:0] rand_en;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t (k=%0d): got %0h expected %0h", tag, $time, k, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0001100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] shown_nibble(input int d);
`ifdef SEVENSEG_LZB_EN
    bit all_zero;
    all_zero = (d != 0);
    for (int i = d; i < N; i++) if (p_active[i] != 4'h0) all_zero = 0;
    if (all_zero) return 4'hF;
`endif
    return p_active[d];
  endfunction

  task automatic model_reset();
    k = 0;
    m_pending = 1'b0;
    p_en = 4'hF;
    for (int i = 0; i < N; i++) begin
      m_active[i] = 4'hF;
      m_shadow[i] = 4'hF;
      p_active[i] = 4'hF;
    end
  endtask

  task automatic check_cycle();
    logic [3:0] exp_an;
    logic [6:0] exp_segs;
    logic       exp_fd;
    int j, pos, d;
    exp_an   = 4'hF;
    exp_segs = 7'h7F;
    if (k > 0) begin
      j   = k - 1;
      pos = j % RD;
      d   = (j / RD) % N;
      if (pos >= BC && p_en[d]) begin
        exp_an   = ~(4'b0001 << d);
        exp_segs = seg_of(shown_nibble(d));
      end
    end
    exp_fd = ((k % RD) == RD - 1) && (((k / RD) % N) == N - 1);
    check_val("an", {28'd0, an}, {28'd0, exp_an});
    check_val("segs", {25'd0, segs}, {25'd0, exp_segs});
    check_val("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
    check_val("pending", {31'd0, dut.pending_q}, {31'd0, m_pending});
  endtask

  task automatic apply_and_advance(input logic ld, input logic [15:0] dat, input logic [3:0] en);
    bit fend;
    load     = ld;
    data_in  = dat;
    digit_en = en;
    p_en     = en;
    for (int i = 0; i < N; i++) p_active[i] = m_active[i];
    fend = ((k % RD) == RD - 1) && (((k / RD) % N) == N - 1);
    if (fend && ld) begin
      for (int i = 0; i < N; i++) begin
        m_active[i] = dat[4*i +: 4];
        m_shadow[i] = dat[4*i +: 4];
      end
      m_pending = 1'b0;
    end else if (fend && m_pending) begin
      for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
      m_pending = 1'b0;
    end else if (ld) begin
      for (int i = 0; i < N; i++) m_shadow[i] = dat[4*i +: 4];
      m_pending = 1'b1;
    end
    k++;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    for (int i = 0; i < 4; i++) begin
      w[4*i +: 4] = ($urandom_range(0, 5) < 2) ? 4'h0 : 4'($urandom_range(0, 15));
    end
    return w;
  endfunction

  initial begin
    logic        ld;
    logic [15:0] dat;
    logic [3:0]  en;
    int f, kk;

    model_reset();
    rand_en = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_an", {28'd0, an}, 32'hF);
    check_val("reset_segs", {25'd0, segs}, 32'h7F);
    check_val("reset_fd", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;

    for (int c = 0; c < 62 * FR; c++) begin
      if (c > 0) @(negedge clk);
      check_cycle();
      f   = c / FR;
      kk  = c % FR;
      ld  = 1'b0;
      dat = 16'($urandom);
      en  = 4'hF;
      if (f == 2 && kk == 13)             begin ld = 1'b1; dat = 16'h1234; end
      if (f == 4 && kk == 3)              begin ld = 1'b1; dat = 16'h1111; end
      if (f == 4 && kk == 20)             begin ld = 1'b1; dat = 16'h5678; end
      if (f == 6 && kk == FR - 1)         begin ld = 1'b1; dat = 16'h9999; end
      if (f == 7 || f == 8)               en = 4'b0101;
      if (f == 9 && kk == 4)              begin ld = 1'b1; dat = 16'h0070; end
      if (f == 11 && kk == 4)             begin ld = 1'b1; dat = 16'h0000; end
      if (f >= 14 && f < 61) begin
        if ($urandom_range(0, 11) == 0) begin ld = 1'b1; dat = rand_word(); end
        if ($urandom_range(0, 39) == 0) rand_en = 4'($urandom_range(0, 15));
        en = rand_en;
      end
      apply_and_advance(ld, dat, en);
    end

    // Last cycle of digit 3's slot: anode 3 is lit, then reset lands between edges.
    @(negedge clk);
    check_cycle();
    #1 rst_n = 1'b0;
    #2;
    check_val("async_rst_an", {28'd0, an}, 32'hF);
    check_val("async_rst_segs", {25'd0, segs}, 32'h7F);
    check_val("async_rst_fd", {31'd0, frame_done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 3 * FR + 1; c++) begin
      if (c > 0) @(negedge clk);
      check_cycle();
      ld  = (c == 3);
      dat = (c == 3) ? 16'h0042 : 16'($urandom);
      apply_and_advance(ld, dat, 4'hF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
